// File: rtl/spi_reg_slave_if.sv
// Register-bank access bus driven by the SPI register slave.
// The slave drives address, write data and strobes; the bank returns read data.
interface spi_reg_slave_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic              reg_wr;
   logic              reg_rd;
   logic [DATA_W-1:0] reg_rdata;

   modport master (
      output reg_addr,
      output reg_wdata,
      output reg_wr,
      output reg_rd,
      input  reg_rdata
   );

   modport slave (
      input  reg_addr,
      input  reg_wdata,
      input  reg_wr,
      input  reg_rd,
      output reg_rdata
   );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave that oversamples the pads in the clk_osc domain and turns
// command/address/data frames into single-cycle register read/write strobes.
module spi_reg_slave #(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk_osc,
   input  logic            rst_n,
   input  logic            spi_cs,
   input  logic            spi_clk,
   input  logic            spi_mosi,
   output logic            spi_miso,
   spi_reg_slave_if.master bus,
   output logic            busy,
   output logic            frame_err
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA
   } state_t;

   logic [SYNC_STAGES-1:0] cs_sync_reg;
   logic [SYNC_STAGES-1:0] sck_sync_reg;
   logic [SYNC_STAGES-1:0] mosi_sync_reg;
   logic                   cs_prev_reg;
   logic                   sck_prev_reg;

   state_t              state_reg;
   logic [CNT_W-1:0]    bit_cnt_reg;
   logic                rw_reg;
   logic [DATA_W-2:0]   rx_reg;
   logic [DATA_W-1:0]   tx_reg;
   logic                cap_pending_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic                wr_reg;
   logic                rd_reg;
   logic                miso_reg;
   logic                busy_reg;
   logic                frame_err_reg;

   logic                cs_s;
   logic                sck_s;
   logic                mosi_s;
   logic                cs_fall;
   logic                cs_rise;
   logic                sck_rise;
   logic                sck_fall;
   logic [DATA_W-1:0]   rx_shift;
   logic                cmd_done;
   logic                word_done;
   logic                on_boundary;

   // Equal-depth synchronizers keep CS, SCK and MOSI aligned to each other.
   always_ff @(posedge clk_osc or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync_reg   <= '1;
         sck_sync_reg  <= '0;
         mosi_sync_reg <= '0;
         cs_prev_reg   <= 1'b1;
         sck_prev_reg  <= 1'b0;
      end else begin
         cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs};
         sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], spi_clk};
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
         cs_prev_reg   <= cs_sync_reg[SYNC_STAGES-1];
         sck_prev_reg  <= sck_sync_reg[SYNC_STAGES-1];
      end
   end

   assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
   assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
   assign cs_fall  = cs_prev_reg & ~cs_s;
   assign cs_rise  = ~cs_prev_reg & cs_s;
   assign sck_rise = sck_s & ~sck_prev_reg;
   assign sck_fall = ~sck_s & sck_prev_reg;

   assign rx_shift    = {rx_reg, mosi_s};
   assign cmd_done    = sck_rise && (bit_cnt_reg == CNT_W'(ADDR_W));
   assign word_done   = sck_rise && (bit_cnt_reg == CNT_W'(DATA_W - 1));
   assign on_boundary = ((state_reg == CMD) && cmd_done) || ((state_reg == DATA) && word_done);

   always_ff @(posedge clk_osc or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         bit_cnt_reg     <= '0;
         rw_reg          <= 1'b0;
         rx_reg          <= '0;
         tx_reg          <= '0;
         cap_pending_reg <= 1'b0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         wr_reg          <= 1'b0;
         rd_reg          <= 1'b0;
         miso_reg        <= 1'b0;
         busy_reg        <= 1'b0;
         frame_err_reg   <= 1'b0;
      end else begin
         wr_reg          <= 1'b0;
         rd_reg          <= 1'b0;
         frame_err_reg   <= 1'b0;
         cap_pending_reg <= rd_reg;

         // Post-write increment keeps the address stable for the whole strobe.
         if (wr_reg) begin
            addr_reg <= addr_reg + 1'b1;
         end
         // Read data is valid the cycle after reg_rd.
         if (cap_pending_reg) begin
            tx_reg <= bus.reg_rdata;
         end

         case (state_reg)
            IDLE: begin
               if (cs_fall) begin
                  state_reg   <= CMD;
                  bit_cnt_reg <= '0;
                  busy_reg    <= 1'b1;
               end
            end
            CMD: begin
               if (sck_rise) begin
                  rx_reg <= rx_shift[DATA_W-2:0];
                  if (cmd_done) begin
                     addr_reg    <= rx_shift[ADDR_W-1:0];
                     rw_reg      <= rx_shift[ADDR_W];
                     rd_reg      <= rx_shift[ADDR_W];
                     bit_cnt_reg <= '0;
                     state_reg   <= DATA;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
               end
            end
            DATA: begin
               if (sck_rise) begin
                  rx_reg <= rx_shift[DATA_W-2:0];
                  if (word_done) begin
                     bit_cnt_reg <= '0;
                     if (rw_reg) begin
                        addr_reg <= addr_reg + 1'b1;
                        rd_reg   <= 1'b1;
                     end else begin
                        wdata_reg <= rx_shift;
                        wr_reg    <= 1'b1;
                     end
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
               end
               if (rw_reg && sck_fall) begin
                  miso_reg <= tx_reg[DATA_W-1];
                  tx_reg   <= {tx_reg[DATA_W-2:0], 1'b0};
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase

         // CS release overrides everything above; a completed word still commits.
         if (cs_rise && (state_reg != IDLE)) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            miso_reg      <= 1'b0;
            bit_cnt_reg   <= '0;
            frame_err_reg <= (bit_cnt_reg != '0) && !on_boundary;
         end
      end
   end

   assign spi_miso      = miso_reg;
   assign busy          = busy_reg;
   assign frame_err     = frame_err_reg;
   assign bus.reg_addr  = addr_reg;
   assign bus.reg_wdata = wdata_reg;
   assign bus.reg_wr    = wr_reg;
   assign bus.reg_rd    = rd_reg;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: an SPI mode-0 master at clk_osc/8 plus a
// register-bank model that answers reads one cycle after reg_rd.
module tb_spi_reg_slave;

   localparam int HP = 4;

   logic clk_osc  = 1'b0;
   logic rst_n    = 1'b1;
   logic spi_cs   = 1'b1;
   logic spi_clk  = 1'b0;
   logic spi_mosi = 1'b0;
   logic spi_miso;
   logic busy;
   logic frame_err;

   always #5 clk_osc = ~clk_osc;

   spi_reg_slave_if #(.ADDR_W(7), .DATA_W(16)) bus_if ();

   spi_reg_slave #(
      .ADDR_W      (7),
      .DATA_W      (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk_osc   (clk_osc),
      .rst_n     (rst_n),
      .spi_cs    (spi_cs),
      .spi_clk   (spi_clk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .bus       (bus_if),
      .busy      (busy),
      .frame_err (frame_err)
   );

   logic [15:0] rmem [0:127];
   logic [6:0]  wr_addr_q [$];
   logic [15:0] wr_data_q [$];
   logic [6:0]  rd_addr_q [$];
   int          ferr_cnt = 0;
   int          both_cnt = 0;
   int          n_vec    = 0;
   int          n_err    = 0;

   // Register bank: data valid only in the cycle after reg_rd.
   always @(posedge clk_osc) begin
      bus_if.reg_rdata <= bus_if.reg_rd ? rmem[bus_if.reg_addr] : 16'hDEAD;
   end

   always @(negedge clk_osc) begin
      if (bus_if.reg_wr) begin
         wr_addr_q.push_back(bus_if.reg_addr);
         wr_data_q.push_back(bus_if.reg_wdata);
      end
      if (bus_if.reg_rd) rd_addr_q.push_back(bus_if.reg_addr);
      if (bus_if.reg_wr && bus_if.reg_rd) both_cnt++;
      if (frame_err) ferr_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %-14s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] wr_addr_at(input int i);
      return (i < wr_addr_q.size()) ? wr_addr_q[i] : 7'bx;
   endfunction

   function automatic logic [15:0] wr_data_at(input int i);
      return (i < wr_data_q.size()) ? wr_data_q[i] : 16'bx;
   endfunction

   function automatic logic [6:0] rd_addr_at(input int i);
      return (i < rd_addr_q.size()) ? rd_addr_q[i] : 7'bx;
   endfunction

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_addr_q.delete();
      ferr_cnt = 0;
   endtask

   task automatic spi_start();
      @(negedge clk_osc);
      spi_cs = 1'b0;
      repeat (HP) @(negedge clk_osc);
   endtask

   // Shifts out w[n-1:0] MSB first; returns MISO as sampled at each SCK rise.
   task automatic spi_bits(input logic [15:0] w, input int n, output logic [15:0] r);
      r = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_mosi = w[i];
         repeat (HP) @(negedge clk_osc);
         r = {r[14:0], spi_miso};
         spi_clk = 1'b1;
         repeat (HP) @(negedge clk_osc);
         spi_clk = 1'b0;
      end
   endtask

   task automatic spi_stop();
      repeat (HP) @(negedge clk_osc);
      spi_cs   = 1'b1;
      spi_mosi = 1'b0;
      repeat (6 * HP) @(negedge clk_osc);
   endtask

   initial begin
      logic [15:0] r;
      logic [6:0]  exp_a [3];
      for (int i = 0; i < 128; i++) rmem[i] = 16'(i * 257);
      rmem[10] = 16'h1234;

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk_osc);
      $display("txn reset");
      chk("rst_miso",  spi_miso, 0);
      chk("rst_addr",  bus_if.reg_addr, 0);
      chk("rst_wdata", bus_if.reg_wdata, 0);
      chk("rst_wr",    bus_if.reg_wr, 0);
      chk("rst_rd",    bus_if.reg_rd, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_ferr",  frame_err, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk_osc);
      clear_log();

      $display("txn write cmd=05 data=a5c3");
      spi_start();
      chk("busy_on", busy, 1);
      spi_bits(16'h0005, 8, r);
      chk("miso_cmd", r, 0);
      spi_bits(16'hA5C3, 16, r);
      chk("miso_wr", r, 0);
      spi_stop();
      chk("wr_cnt1",  wr_addr_q.size(), 1);
      chk("wr_addr1", wr_addr_at(0), 7'h05);
      chk("wr_data1", wr_data_at(0), 16'hA5C3);
      chk("rd_cnt1",  rd_addr_q.size(), 0);
      chk("ferr1",    ferr_cnt, 0);
      chk("busy_off", busy, 0);
      clear_log();

      $display("txn read cmd=8a");
      spi_start();
      spi_bits(16'h008A, 8, r);
      spi_bits(16'h0000, 16, r);
      chk("rd_word2", r, 16'h1234);
      spi_stop();
      chk("rd_cnt2",  rd_addr_q.size(), 2);
      chk("rd_addr2", rd_addr_at(0), 7'h0A);
      chk("rd_pref2", rd_addr_at(1), 7'h0B);
      chk("wr_cnt2",  wr_addr_q.size(), 0);
      chk("ferr2",    ferr_cnt, 0);
      clear_log();

      $display("txn burst write cmd=7e words=1,2,3");
      spi_start();
      spi_bits(16'h007E, 8, r);
      for (int i = 1; i <= 3; i++) spi_bits(16'(i), 16, r);
      spi_stop();
      exp_a[0] = 7'h7E;
      exp_a[1] = 7'h7F;
      exp_a[2] = 7'h00;
      chk("wr_cnt3", wr_addr_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("wr_addr3_%0d", i), wr_addr_at(i), exp_a[i]);
         chk($sformatf("wr_data3_%0d", i), wr_data_at(i), 16'(i + 1));
      end
      chk("ferr3", ferr_cnt, 0);
      clear_log();

      $display("txn burst read cmd=80 words=3");
      spi_start();
      spi_bits(16'h0080, 8, r);
      for (int i = 0; i < 3; i++) begin
         spi_bits(16'h0000, 16, r);
         chk($sformatf("rd_word4_%0d", i), r, 16'(i * 257));
      end
      spi_stop();
      chk("rd_cnt4", rd_addr_q.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("rd_addr4_%0d", i), rd_addr_at(i), 7'(i));
      chk("ferr4", ferr_cnt, 0);
      clear_log();

      $display("txn abort after 5 command bits");
      spi_start();
      spi_bits(16'h0003, 5, r);
      spi_stop();
      chk("ferr5a",   ferr_cnt, 1);
      chk("wr_cnt5a", wr_addr_q.size(), 0);
      clear_log();

      $display("txn abort after 9 data bits cmd=10");
      spi_start();
      spi_bits(16'h0010, 8, r);
      spi_bits(16'h01FF, 9, r);
      spi_stop();
      chk("ferr5b",   ferr_cnt, 1);
      chk("wr_cnt5b", wr_addr_q.size(), 0);
      clear_log();

      $display("txn write cmd=03 data=beef");
      spi_start();
      spi_bits(16'h0003, 8, r);
      spi_bits(16'hBEEF, 16, r);
      spi_stop();
      chk("wr_cnt5c",  wr_addr_q.size(), 1);
      chk("wr_addr5c", wr_addr_at(0), 7'h03);
      chk("wr_data5c", wr_data_at(0), 16'hBEEF);
      chk("ferr5c",    ferr_cnt, 0);
      clear_log();

      $display("txn burst read cmd=fe with reset in second word");
      spi_start();
      spi_bits(16'h00FE, 8, r);
      spi_bits(16'h0000, 16, r);
      chk("rd_word6", r, 16'h7E7E);
      spi_bits(16'h0000, 3, r);
      repeat (3) @(negedge clk_osc);
      chk("miso_pre6", spi_miso, 1);
      chk("busy_pre6", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("ar_miso",  spi_miso, 0);
      chk("ar_addr",  bus_if.reg_addr, 0);
      chk("ar_wdata", bus_if.reg_wdata, 0);
      chk("ar_wr",    bus_if.reg_wr, 0);
      chk("ar_rd",    bus_if.reg_rd, 0);
      chk("ar_busy",  busy, 0);
      chk("ar_ferr",  frame_err, 0);
      @(negedge clk_osc);
      spi_cs   = 1'b1;
      spi_clk  = 1'b0;
      spi_mosi = 1'b0;
      repeat (4) @(negedge clk_osc);
      rst_n = 1'b1;
      repeat (4) @(negedge clk_osc);
      clear_log();

      $display("txn write cmd=22 data=5a5a after reset");
      spi_start();
      spi_bits(16'h0022, 8, r);
      spi_bits(16'h5A5A, 16, r);
      spi_stop();
      chk("wr_cnt7",  wr_addr_q.size(), 1);
      chk("wr_addr7", wr_addr_at(0), 7'h22);
      chk("wr_data7", wr_data_at(0), 16'h5A5A);
      chk("ferr7",    ferr_cnt, 0);
      clear_log();

      $display("txn read cmd=8a after reset");
      spi_start();
      spi_bits(16'h008A, 8, r);
      spi_bits(16'h0000, 16, r);
      chk("rd_word8", r, 16'h1234);
      spi_stop();
      chk("rd_addr8", rd_addr_at(0), 7'h0A);

      chk("wr_rd_overlap", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
